// File: rtl/stream_demux_buf.sv
// Buffered valid/ready demultiplexer: one input stream is steered per beat to one of
// N_OUP outputs, each fronted by a 2-entry skid buffer so input ready never sees output ready.
module stream_demux_buf #(
   parameter type         DATA_T = logic,
   parameter int unsigned N_OUP  = 2,
   parameter int unsigned SEL_W  = (N_OUP > 1) ? $clog2(N_OUP) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  DATA_T                  inp_data_i,
   input  logic                   inp_valid_i,
   output logic                   inp_ready_o,
   input  logic [SEL_W-1:0]       inp_sel_i,
   output DATA_T [N_OUP-1:0]      oup_data_o,
   output logic  [N_OUP-1:0]      oup_valid_o,
   input  logic  [N_OUP-1:0]      oup_ready_i,
   output logic                   sel_err_o
);

   localparam int unsigned CNT_W = 2;
   typedef logic [CNT_W-1:0] cnt_t;

   cnt_t  [N_OUP-1:0] cnt_q,   cnt_d;
   DATA_T [N_OUP-1:0] head_q,  head_d;
   DATA_T [N_OUP-1:0] tail_q,  tail_d;
   logic  [N_OUP-1:0] valid_q, valid_d;
   logic              err_q,   err_d;

   logic [N_OUP-1:0]  sel_oh;
   logic [N_OUP-1:0]  full;
   logic              in_range;
   logic              push_any;

   // Select decode; a single-output instance ignores the select entirely.
   always_comb begin
      sel_oh   = '0;
      full     = '0;
      in_range = 1'b0;
      for (int unsigned k = 0; k < N_OUP; k++) begin
         full[k] = (cnt_q[k] == cnt_t'(2));
         if ((N_OUP == 1) || (inp_sel_i == SEL_W'(k))) begin
            sel_oh[k] = 1'b1;
            in_range  = 1'b1;
         end
      end
   end

   // Out-of-range beats see no full buffer, so they are accepted and dropped.
   assign inp_ready_o = !rst_i && !(|(sel_oh & full));
   assign push_any    = inp_valid_i && inp_ready_o;

   always_comb begin
      cnt_d   = cnt_q;
      head_d  = head_q;
      tail_d  = tail_q;
      valid_d = valid_q;
      err_d   = err_q | (push_any && !in_range);
      for (int unsigned k = 0; k < N_OUP; k++) begin
         case ({push_any && sel_oh[k], valid_q[k] && oup_ready_i[k]})
            2'b10: begin
               cnt_d[k] = cnt_t'(cnt_q[k] + cnt_t'(1));
               if (cnt_q[k] == cnt_t'(0)) head_d[k] = inp_data_i;
               else                       tail_d[k] = inp_data_i;
            end
            2'b01: begin
               cnt_d[k]  = cnt_t'(cnt_q[k] - cnt_t'(1));
               head_d[k] = tail_q[k];
            end
            // Push and pop together only happen at one entry: new beat replaces head.
            2'b11:   head_d[k] = inp_data_i;
            default: ;
         endcase
         valid_d[k] = (cnt_d[k] != cnt_t'(0));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= '0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign oup_data_o  = head_q;
   assign oup_valid_o = valid_q;
   assign sel_err_o   = err_q;

`ifndef COMMON_CELLS_ASSERTS_OFF
   a_n_oup: assert property (@(posedge clk_i) N_OUP >= 1)
      else $error("stream_demux_buf: N_OUP must be at least 1");

   a_inp_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (inp_valid_i && !inp_ready_o) |=> ($stable(inp_data_i) && $stable(inp_sel_i)))
      else $error("stream_demux_buf: input changed while stalled");

   for (genvar k = 0; k < N_OUP; k++) begin : g_oup_asrt
      a_oup_hold: assert property (@(posedge clk_i) disable iff (rst_i)
         (oup_valid_o[k] && !oup_ready_i[k]) |=> oup_valid_o[k])
         else $error("stream_demux_buf: output valid dropped without pop");
   end
`endif

endmodule
